// File: rtl/hdmi_fmt_pkg.sv
// rtl/hdmi_fmt_pkg.sv - shared mode encodings, pipeline depth and colour-bar tables
package hdmi_fmt_pkg;

  typedef enum logic [1:0] {
    MODE_DDR422 = 2'd0,
    MODE_SDR16  = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  localparam int FMT_LATENCY = 2;

  // 8-bit BT.601 levels, white..black; scaled to DATA_W by MSB alignment at use
  localparam logic [7:0] BAR_Y  [8] = '{8'd235, 8'd210, 8'd170, 8'd145, 8'd106, 8'd81,  8'd41,  8'd16};
  localparam logic [7:0] BAR_CB [8] = '{8'd128, 8'd16,  8'd166, 8'd54,  8'd202, 8'd90,  8'd240, 8'd128};
  localparam logic [7:0] BAR_CR [8] = '{8'd128, 8'd146, 8'd16,  8'd34,  8'd222, 8'd240, 8'd110, 8'd128};

endpackage

// File: rtl/hdmi_video_formatter_if.sv
// rtl/hdmi_video_formatter_if.sv - pixel-side input and pad-side output bundle of the formatter
interface hdmi_video_formatter_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] c;
  logic              hsync_in;
  logic              vsync_in;
  logic              de_in;
  logic [OUT_W-1:0]  d_rise;
  logic [OUT_W-1:0]  d_fall;
  logic              de_out;
  logic              hsync_out;
  logic              vsync_out;

  modport master (
    output y, c, hsync_in, vsync_in, de_in,
    input  d_rise, d_fall, de_out, hsync_out, vsync_out
  );

  modport slave (
    input  y, c, hsync_in, vsync_in, de_in,
    output d_rise, d_fall, de_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/video_timing_measure.sv
// rtl/video_timing_measure.sv - frame start detect, pixel/line counting and frame geometry latch
module video_timing_measure #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic             fs,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CNT_W-1:0] active_width,
  output logic [CNT_W-1:0] active_height,
  output logic             timing_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_q;
  logic             de_q;
  logic             de_fall;
  logic [CNT_W-1:0] line_w;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] line_w_next;
  logic [CNT_W-1:0] line_cnt_next;

  assign fs      = vsync_in & ~vs_q;
  assign de_fall = ~de_in & de_q;

  // A line ending on the frame-start cycle still belongs to the frame being closed
  always_comb begin
    line_w_next   = line_w;
    line_cnt_next = line_cnt;
    if (de_fall) begin
      line_w_next = pix_cnt;
      if (line_cnt != CNT_MAX) line_cnt_next = line_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      pix_cnt       <= '0;
      line_w        <= '0;
      line_cnt      <= '0;
      active_width  <= '0;
      active_height <= '0;
      timing_stable <= 1'b0;
    end else begin
      vs_q   <= vsync_in;
      de_q   <= de_in;
      line_w <= line_w_next;
      if (de_in) begin
        if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_W'(1);
      end else if (de_fall) begin
        pix_cnt <= '0;
      end
      if (fs) begin
        active_width  <= line_w_next;
        active_height <= line_cnt_next;
        timing_stable <= (line_w_next == active_width) && (line_cnt_next == active_height) &&
                         (line_w_next != '0) && (line_cnt_next != '0);
        line_cnt      <= '0;
      end else begin
        line_cnt <= line_cnt_next;
      end
    end
  end

endmodule

// File: rtl/hdmi_video_formatter.sv
// rtl/hdmi_video_formatter.sv - mode-selectable DDR/SDR/bars/blank formatter feeding the ADV7511 pads
module hdmi_video_formatter
  import hdmi_fmt_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 16,
  parameter int HS_POL    = 1,
  parameter int VS_POL    = 1,
  parameter int CNT_W     = 12,
  parameter int BAR_SHIFT = 4
) (
  input  logic                clk,
  input  logic                reset,
  hdmi_video_formatter_if.slave vid,
  input  logic [1:0]          mode,
  output logic [1:0]          mode_active,
  output logic [CNT_W-1:0]    active_width,
  output logic [CNT_W-1:0]    active_height,
  output logic                timing_stable
);

  localparam logic             HS_ACT    = 1'(HS_POL);
  localparam logic             VS_ACT    = 1'(VS_POL);
  localparam logic [OUT_W-1:0] DATA_MASK = ~({OUT_W{1'b1}} >> DATA_W);

  logic             fs;
  logic [CNT_W-1:0] pix_cnt;
  logic             unused_pix;
  mode_e            mode_eff;
  logic [2:0]       bar;
  logic [OUT_W-1:0] rise_c;
  logic [OUT_W-1:0] fall_c;

  logic [OUT_W-1:0] rise_q [FMT_LATENCY];
  logic [OUT_W-1:0] fall_q [FMT_LATENCY];
  logic             de_q   [FMT_LATENCY];
  logic             hs_q   [FMT_LATENCY];
  logic             vs_q   [FMT_LATENCY];

  video_timing_measure #(.CNT_W(CNT_W)) u_measure (
    .clk           (clk),
    .reset         (reset),
    .vsync_in      (vid.vsync_in),
    .de_in         (vid.de_in),
    .fs            (fs),
    .pix_cnt       (pix_cnt),
    .active_width  (active_width),
    .active_height (active_height),
    .timing_stable (timing_stable)
  );

  assign unused_pix = ^pix_cnt;

  function automatic logic [OUT_W-1:0] bar_scale(input logic [7:0] v);
    return (OUT_W'(v) << (OUT_W - 8)) & DATA_MASK;
  endfunction

  // The frame-start cycle itself is already formatted in the newly requested mode
  assign mode_eff = mode_e'(fs ? mode : mode_active);
  assign bar      = pix_cnt[BAR_SHIFT+2:BAR_SHIFT];

  always_comb begin
    rise_c = '0;
    fall_c = '0;
    if (vid.de_in) begin
      case (mode_eff)
        MODE_DDR422: begin
          rise_c = OUT_W'(vid.y) << (OUT_W - DATA_W);
          fall_c = OUT_W'(vid.c) << (OUT_W - DATA_W);
        end
        MODE_SDR16: begin
          rise_c = OUT_W'({vid.y, vid.c}) << (OUT_W - 2*DATA_W);
          fall_c = OUT_W'({vid.y, vid.c}) << (OUT_W - 2*DATA_W);
        end
        MODE_BARS: begin
          rise_c = bar_scale(BAR_Y[bar]);
          fall_c = bar_scale(pix_cnt[0] ? BAR_CR[bar] : BAR_CB[bar]);
        end
        default: begin
          rise_c = '0;
          fall_c = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active <= MODE_BLANK;
      for (int i = 0; i < FMT_LATENCY; i++) begin
        rise_q[i] <= '0;
        fall_q[i] <= '0;
        de_q[i]   <= 1'b0;
        hs_q[i]   <= ~HS_ACT;
        vs_q[i]   <= ~VS_ACT;
      end
    end else begin
      if (fs) mode_active <= mode;
      rise_q[0] <= rise_c;
      fall_q[0] <= fall_c;
      de_q[0]   <= vid.de_in;
      hs_q[0]   <= vid.hsync_in ~^ HS_ACT;
      vs_q[0]   <= vid.vsync_in ~^ VS_ACT;
      for (int i = 1; i < FMT_LATENCY; i++) begin
        rise_q[i] <= rise_q[i-1];
        fall_q[i] <= fall_q[i-1];
        de_q[i]   <= de_q[i-1];
        hs_q[i]   <= hs_q[i-1];
        vs_q[i]   <= vs_q[i-1];
      end
    end
  end

  assign vid.d_rise    = rise_q[FMT_LATENCY-1];
  assign vid.d_fall    = fall_q[FMT_LATENCY-1];
  assign vid.de_out    = de_q[FMT_LATENCY-1];
  assign vid.hsync_out = hs_q[FMT_LATENCY-1];
  assign vid.vsync_out = vs_q[FMT_LATENCY-1];

endmodule

// File: tb/tb_hdmi_video_formatter.sv
// tb/tb_hdmi_video_formatter.sv - randomized bench with behavioural formatter model and directed literal checks
module tb_hdmi_video_formatter;

  localparam int HS_POL = 0;
  localparam int VS_POL = 1;
  localparam int PMAX   = 4095;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  mode_active;
  logic [11:0] active_width;
  logic [11:0] active_height;
  logic        timing_stable;

  hdmi_video_formatter_if #(.DATA_W(8), .OUT_W(16)) vid();

  hdmi_video_formatter #(
    .DATA_W(8), .OUT_W(16), .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(12), .BAR_SHIFT(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vid           (vid.slave),
    .mode          (mode),
    .mode_active   (mode_active),
    .active_width  (active_width),
    .active_height (active_height),
    .timing_stable (timing_stable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-cycle expectation pushed through a 2-deep delay line
  typedef struct packed {
    logic [15:0] r;
    logic [15:0] f;
    logic        de;
    logic        hs;
    logic        vs;
  } out_t;

  logic [7:0] tb_y  [8] = '{235, 210, 170, 145, 106, 81, 41, 16};
  logic [7:0] tb_cb [8] = '{128, 16, 166, 54, 202, 90, 240, 128};
  logic [7:0] tb_cr [8] = '{128, 146, 16, 34, 222, 240, 110, 128};

  out_t p1, p2, rst_out;
  bit   model_live = 0;
  int   m_prev_vs, m_prev_de, m_px, m_line_w, m_lines, m_aw, m_ah, m_st, m_mode;

  function automatic out_t model_out(input int md, input bit de, input bit hs, input bit vs,
                                     input logic [7:0] yy, input logic [7:0] cc, input int px);
    out_t o;
    int   b;
    o.de = de;
    o.hs = (HS_POL != 0) ? hs : !hs;
    o.vs = (VS_POL != 0) ? vs : !vs;
    o.r  = 16'h0;
    o.f  = 16'h0;
    if (de) begin
      b = (px / 16) % 8;
      case (md)
        0: begin o.r = {yy, 8'h00}; o.f = {cc, 8'h00}; end
        1: begin o.r = {yy, cc};    o.f = {yy, cc};    end
        2: begin o.r = {tb_y[b], 8'h00}; o.f = {(px % 2 == 1) ? tb_cr[b] : tb_cb[b], 8'h00}; end
        default: ;
      endcase
    end
    return o;
  endfunction

  initial begin
    rst_out = '0;
    rst_out.hs = (HS_POL != 0) ? 1'b0 : 1'b1;
    rst_out.vs = (VS_POL != 0) ? 1'b0 : 1'b1;
  end

  always @(posedge clk) begin
    bit   fs, fall;
    int   md;
    out_t n;
    if (reset) begin
      p1 = rst_out; p2 = rst_out;
      m_prev_vs = 0; m_prev_de = 0; m_px = 0; m_line_w = 0; m_lines = 0;
      m_aw = 0; m_ah = 0; m_st = 0; m_mode = 3;
      model_live = 1;
    end else if (model_live) begin
      fs   = vid.vsync_in && (m_prev_vs == 0);
      fall = !vid.de_in && (m_prev_de == 1);
      md   = fs ? int'(mode) : m_mode;
      n    = model_out(md, vid.de_in, vid.hsync_in, vid.vsync_in, vid.y, vid.c, m_px);
      p2   = p1;
      p1   = n;
      if (fall) begin
        m_line_w = m_px;
        m_lines  = (m_lines < PMAX) ? m_lines + 1 : PMAX;
        m_px     = 0;
      end
      if (vid.de_in) m_px = (m_px < PMAX) ? m_px + 1 : PMAX;
      if (fs) begin
        m_st    = (m_line_w == m_aw && m_lines == m_ah && m_line_w != 0 && m_lines != 0) ? 1 : 0;
        m_aw    = m_line_w;
        m_ah    = m_lines;
        m_lines = 0;
        m_mode  = int'(mode);
      end
      m_prev_vs = int'(vid.vsync_in);
      m_prev_de = int'(vid.de_in);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("d_rise",        vid.d_rise,     p2.r);
      chk("d_fall",        vid.d_fall,     p2.f);
      chk("de_out",        vid.de_out,     p2.de);
      chk("hsync_out",     vid.hsync_out,  p2.hs);
      chk("vsync_out",     vid.vsync_out,  p2.vs);
      chk("mode_active",   mode_active,    m_mode);
      chk("active_width",  active_width,   m_aw);
      chk("active_height", active_height,  m_ah);
      chk("timing_stable", timing_stable,  m_st);
    end
  end

  function automatic logic [7:0] rb();
    return 8'($urandom);
  endfunction

  task automatic drive(input bit de, input bit hs, input bit vs, input logic [7:0] yy, input logic [7:0] cc);
    vid.de_in = de; vid.hsync_in = hs; vid.vsync_in = vs; vid.y = yy; vid.c = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, rb(), rb());
  endtask

  task automatic vs_pulse(input int n);
    repeat (n) drive(0, 0, 1, rb(), rb());
    drive(0, 0, 0, rb(), rb());
  endtask

  task automatic one_line(input int w, input int blank, input bit bar_chk);
    for (int k = 0; k < w; k++) begin
      if (bar_chk && k == 18) begin
        chk("bars_y_pix16",  vid.d_rise, 16'hD200);
        chk("bars_cb_pix16", vid.d_fall, 16'h1000);
      end
      if (bar_chk && k == 19) chk("bars_cr_pix17", vid.d_fall, 16'h9200);
      drive(1, 0, 0, rb(), rb());
    end
    for (int b = 0; b < blank; b++) drive(0, b < 2, 0, rb(), rb());
  endtask

  task automatic lines(input int nl, input int w, input bit bar_chk);
    for (int l = 0; l < nl; l++) one_line(w, 6, bar_chk && l == 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vid.y = 8'h00; vid.c = 8'h00; vid.de_in = 1'b0; vid.hsync_in = 1'b0; vid.vsync_in = 1'b0;
    #1;
    reset = 1'b1;
    idle(2);
    chk("rst_d_rise", vid.d_rise, 16'h0);
    chk("rst_de_out", vid.de_out, 1'b0);
    chk("rst_hsync_out", vid.hsync_out, 1'b1);
    chk("rst_vsync_out", vid.vsync_out, 1'b0);
    chk("rst_mode_active", mode_active, 2'd3);
    chk("rst_timing_stable", timing_stable, 1'b0);
    reset = 1'b0;

    // DDR422 latency and packing, then hsync polarity inversion
    mode = 2'd0;
    vs_pulse(2);
    idle(2);
    chk("ddr_mode_active", mode_active, 2'd0);
    drive(1, 0, 0, 8'h5A, 8'hC3);
    chk("ddr_de_lat1", vid.de_out, 1'b0);
    drive(1, 0, 0, 8'h5A, 8'hC3);
    chk("ddr_d_rise", vid.d_rise, 16'h5A00);
    chk("ddr_d_fall", vid.d_fall, 16'hC300);
    chk("ddr_de_lat2", vid.de_out, 1'b1);
    drive(0, 1, 0, 8'h00, 8'h00);
    chk("hs_lat1", vid.hsync_out, 1'b1);
    drive(0, 1, 0, 8'h00, 8'h00);
    chk("hs_lat2", vid.hsync_out, 1'b0);
    idle(4);

    // Mode request mid-frame waits for the next frame start
    mode = 2'd1;
    repeat (3) drive(1, 0, 0, 8'h12, 8'h34);
    chk("sw_mode_held", mode_active, 2'd0);
    chk("sw_still_ddr", vid.d_rise, 16'h1200);
    idle(3);
    vs_pulse(2);
    chk("sw_mode_new", mode_active, 2'd1);
    repeat (2) drive(1, 0, 0, 8'h12, 8'h34);
    chk("sdr_d_rise", vid.d_rise, 16'h1234);
    chk("sdr_d_fall", vid.d_fall, 16'h1234);
    idle(4);

    // Frame measurement with colour bars running
    mode = 2'd2;
    vs_pulse(2);
    lines(10, 64, 1);
    vs_pulse(2);
    chk("meas_width_fs2", active_width, 12'd64);
    chk("meas_height_fs2", active_height, 12'd10);
    lines(10, 64, 0);
    vs_pulse(2);
    chk("meas_stable_fs3", timing_stable, 1'b1);
    lines(10, 64, 0);
    vs_pulse(2);
    chk("meas_stable_fs4", timing_stable, 1'b1);
    lines(9, 64, 0);
    vs_pulse(2);
    chk("meas_height_9", active_height, 12'd9);
    chk("meas_unstable", timing_stable, 1'b0);

    // Random frames, random mode requests, some line ends coinciding with frame start
    for (int f = 0; f < 10; f++) begin
      int nl, w, chg;
      nl  = $urandom_range(1, 5);
      w   = $urandom_range(1, 40);
      chg = $urandom_range(0, nl - 1);
      for (int l = 0; l < nl; l++) begin
        if (l == chg) mode = 2'($urandom_range(0, 3));
        one_line(w, (l == nl - 1 && ($urandom_range(0, 1) == 1)) ? 0 : $urandom_range(1, 5), 0);
      end
      vs_pulse($urandom_range(1, 3));
    end

    // Reset mid-line, then measurement restarts from zero
    mode = 2'd0;
    vs_pulse(2);
    lines(2, 30, 0);
    repeat (5) drive(1, 0, 0, 8'hAA, 8'hBB);
    reset = 1'b1;
    drive(1, 0, 0, 8'hAA, 8'hBB);
    chk("rst_mid_d_rise", vid.d_rise, 16'h0);
    chk("rst_mid_d_fall", vid.d_fall, 16'h0);
    chk("rst_mid_de_out", vid.de_out, 1'b0);
    chk("rst_mid_mode", mode_active, 2'd3);
    chk("rst_mid_width", active_width, 12'd0);
    reset = 1'b0;
    idle(3);
    lines(3, 20, 0);
    vs_pulse(2);
    chk("post_rst_width", active_width, 12'd20);
    chk("post_rst_height", active_height, 12'd3);
    chk("post_rst_stable", timing_stable, 1'b0);

    // Pixel counter saturation
    lines(1, 4100, 0);
    vs_pulse(2);
    chk("sat_width", active_width, 12'd4095);
    chk("sat_height", active_height, 12'd1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hdmi_video_formatter.md
Name: hdmi_video_formatter

Overview:
Parametrised, technology-independent formatter that sits between the video timing/pixel pipeline and the ADV7511 pad layer. Supports:
- Run-time selectable output modes: DDR 4:2:2, SDR 16-bit, built-in colour-bar test pattern, and blank.
- Configurable sync polarity.
- Measurement of active width and height, with a stable-timing flag.
Produces registered rise/fall data words, DE and syncs, all with fixed latency. A separate pad wrapper feeds these into ODDR cells.

Parameters:
DATA_W, 8, width of each input component (y, c)
OUT_W, 16, width of d_rise/d_fall; must be ≥ 2*DATA_W
HS_POL, 1, output hsync active level (1 = active-high)
VS_POL, 1, output vsync active level
CNT_W, 12, width of pixel/line counters and measurement outputs
BAR_SHIFT, 4, test-pattern bar width = 2^BAR_SHIFT pixels

Ports:
clk  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
y  in  DATA_W  luma
c  in  DATA_W  chroma, alternating Cb/Cr as supplied by the source
hsync_in  in  1  hsync, active-high
vsync_in  in  1  vsync, active-high
de_in  in  1  data enable
mode  in  2  requested mode: 0 = DDR422, 1 = SDR16, 2 = BARS, 3 = BLANK
d_rise  out  OUT_W  word for the rising-edge ODDR input (D1)
d_fall  out  OUT_W  word for the falling-edge ODDR input (D2)
de_out  out  1  aligned data enable
hsync_out  out  1  aligned hsync at HS_POL
vsync_out  out  1  aligned vsync at VS_POL
mode_active  out  2  mode currently applied
active_width  out  CNT_W  DE pixels in the last complete line of the previous frame
active_height  out  CNT_W  DE lines in the previous frame
timing_stable  out  1  the two most recent frame measurements matched and were nonzero

Behaviour:
- Reset, applied synchronously on any cycle including mid-frame:
  - d_rise, d_fall, de_out = 0.
  - hsync_out = ~HS_POL; vsync_out = ~VS_POL.
  - mode_active = 3 (BLANK).
  - active_width, active_height, timing_stable and all internal counters = 0.
- Latency: exactly 2 clk from inputs to all of d_rise, d_fall, de_out, hsync_out, vsync_out, in every mode. Syncs and DE never skew relative to data.
- Sync polarity: sync_out = sync_in when POL = 1, else ~sync_in.
- Frame start (fs): cycle where vsync_in = 1 and its registered copy = 0.
  - At fs, mode_active <= mode. Mode changes take effect only here, never mid-frame.
  - Data of the fs cycle already uses the new mode.
- Pixel counter pix_cnt:
  - Increments on each de_in = 1 cycle.
  - Clears on the cycle after a DE falling edge.
  - Saturates at 2^CNT_W - 1.
- DE falling edge (de_in = 0, previous = 1): line_w <= pix_cnt; line_cnt++ (saturating).
- At fs:
  - active_width <= line_w; active_height <= line_cnt.
  - timing_stable <= (line_w == active_width) && (line_cnt == active_height) && line_w != 0 && line_cnt != 0.
  - line_cnt <= 0.
- fs coincident with a DE falling edge: the falling edge is counted into the ending frame first, then the measurement is latched.
- Data per mode, applied where de = 1. When de = 0, d_rise = d_fall = 0 in all modes. Unused low bits = 0.
  - DDR422: d_rise[OUT_W-1 -: DATA_W] = y; d_fall[OUT_W-1 -: DATA_W] = c.
  - SDR16: d_rise = d_fall = {y, c} left-justified.
  - BARS:
    - bar = pix_cnt[BAR_SHIFT+2:BAR_SHIFT], wrapping every 8 bars.
    - Y and Cb/Cr come from the package BAR table. Cb when pix_cnt[0] = 0, Cr when 1.
    - Packed as in DDR422. Values are scaled to DATA_W by MSB alignment.
  - BLANK: data 0; DE and syncs pass through unchanged.
- Inputs are sampled regardless of mode; the measurement runs in all modes.

Decomposition:
- Package hdmi_fmt_pkg:
  - Mode encodings MODE_DDR422/MODE_SDR16/MODE_BARS/MODE_BLANK.
  - FMT_LATENCY = 2.
  - 8-entry BAR_Y/BAR_CB/BAR_CR tables (8-bit: white 235/128/128, yellow 210/16/146, cyan 170/166/16, green 145/54/34, magenta 106/202/222, red 81/90/240, blue 41/240/110, black 16/128/128).
- Sub-module video_timing_measure:
  - Contains the edge detection, pix_cnt, line_cnt and the latching of active_width, active_height and timing_stable.
  - Exports fs and pix_cnt to the parent.

Test Plan:
- DDR422: y = 0x5A, c = 0xC3, de = 1 → 2 cycles later d_rise = 0x5A00 and d_fall = 0xC300; de_out rises on the same cycle.
- Mode switch: mode changes 0→1 mid-frame → mode_active stays 0 until the next vsync rise. After that, with y = 0x12, c = 0x34, d_rise = d_fall = 0x1234.
- Measurement: 3 frames of 64 DE pixels × 10 lines each:
  - after the 2nd fs, active_width = 64 and active_height = 10;
  - timing_stable = 1 from the 3rd fs;
  - a frame of 9 lines then clears it.
- BARS with BAR_SHIFT = 4: at pix_cnt 16, d_rise = 0xD200 (yellow Y). d_fall = 0x1000 on even pixels and 0x9200 on odd pixels.
- Polarity HS_POL = 0: hsync_in 0→1 → hsync_out 1→0 two cycles later. Reset value of hsync_out = 1.
- Reset asserted mid-line with de = 1 → next cycle all data outputs and de_out = 0 and mode_active = 3. After release, the measurement restarts from 0.
